trigger_capture: RTL and testbench
==================================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter N_SAMPLES, default 640, number of samples written per frame (one per display column).
REQ-002 Parameter HOLDOFF, default 65536, clock cycles between frame end and re-arm.
REQ-003 Parameter AUTO_TIMEOUT, default 1048576, clock cycles in ARMED before a forced (auto) trigger.
REQ-004 Port CLOCK  in  1  50 MHz system clock; the only clock.
REQ-005 Port RESET_N  in  1  asynchronous, active-low reset.
REQ-006 Port sample  in  12  ADC channel-0 code, unsigned.
REQ-007 Port sample_valid  in  1  one-cycle strobe when sample holds a new conversion.
REQ-008 Port trig_level  in  12  trigger threshold, unsigned.
REQ-009 Port trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-010 Port decim  in  3  store one of every 2^decim valid samples (0..7).
REQ-011 Port single  in  1  1 = single-shot mode, 0 = continuous run.
REQ-012 Port arm  in  1  one-cycle pulse starting a capture from IDLE.
REQ-013 Port wr_en  out  1  write strobe to the dual-port frame RAM.
REQ-014 Port wr_addr  out  10  frame RAM address, 0..N_SAMPLES-1.
REQ-015 Port wr_data  out  12  sample to write.
REQ-016 Port frame_done  out  1  one-cycle pulse after the last write of a frame.
REQ-017 Port triggered  out  1  high from trigger event until frame_done.
REQ-018 Port auto_trig  out  1  latched: last frame was started by timeout, not by a level crossing.

Function
REQ-019 States SHALL be IDLE, ARMED, CAPTURE, HOLDOFF.
REQ-020 IDLE -> ARMED on arm=1; in continuous mode IDLE -> ARMED unconditionally the next cycle.
REQ-021 Trigger SHALL be evaluated only on sample_valid cycles, comparing against prev, the last valid sample (registered every valid strobe in every state).
REQ-022 Rising trigger: prev < trig_level and sample >= trig_level; falling: prev > trig_level and sample <= trig_level.
REQ-023 ARMED -> CAPTURE on trigger; the triggering sample SHALL be written at address 0 on that same cycle (wr_en high with the state change), and decimation counter cleared.
REQ-024 ARMED timeout counter counts clocks; at AUTO_TIMEOUT-1 with no trigger, the next valid sample SHALL start the frame as in REQ-023, setting auto_trig=1; a real trigger clears auto_trig.
REQ-025 CAPTURE: decimation counter increments per valid sample, wraps at 2^decim-1; write occurs when counter wraps (decim=0: every valid sample).
REQ-026 wr_addr SHALL increment after each write; write at N_SAMPLES-1 SHALL assert frame_done the following cycle, return wr_addr to 0, enter HOLDOFF.
REQ-027 wr_en SHALL never be high outside a write cycle and never more than once per valid strobe; wr_data equals sample of that cycle (zero latency, registered outputs updated on the same edge as state).
REQ-028 HOLDOFF lasts exactly HOLDOFF cycles, then -> ARMED if single=0, else -> IDLE.
REQ-029 arm pulses outside IDLE SHALL be ignored; changing decim, trig_level or trig_falling mid-frame SHALL take effect on the next valid strobe without corrupting wr_addr.
REQ-030 prev SHALL reset to 0, so a rising trigger at level 0 cannot fire on the first sample.

Reset
REQ-031 RESET_N low SHALL asynchronously force state IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, triggered=0, auto_trig=0, all counters and prev to 0.
REQ-032 Reset mid-CAPTURE SHALL abort the frame; no further writes until a new trigger.

Structure
REQ-033 State encoding and default parameter constants SHALL live in shared package dso_pkg.
REQ-034 Edge detection (prev register and comparators) SHALL be sub-module trig_detect; the rest is one FSM module.

Verification
REQ-035 Ramp 0..4095 step 1, valid every 16 clocks, level 2048 rising, decim 0, continuous -> first write addr 0 data 2048, addr 639 data 2687, frame_done one cycle later.
REQ-036 Same ramp, decim 2 -> writes every 4th valid: addr 1 data 2052, addr 639 data 4604 mod-wrap excluded (use ramp to 5000-capable 12-bit saturate at 4095 checked).
REQ-037 Constant sample 100, level 2048 -> no trigger; after AUTO_TIMEOUT cycles frame starts, auto_trig=1, 640 writes of 100.
REQ-038 single=1, arm pulse -> one frame, then IDLE after HOLDOFF, no writes until second arm pulse.
REQ-039 Falling trigger on descending ramp 4095..0, level 1000 -> addr 0 data 1000.
REQ-040 RESET_N low at write 300 -> outputs zero immediately; after release, next frame starts at addr 0 on trigger.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared oscilloscope capture types: FSM encoding, bus widths, default frame/timing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int SAMPLE_W = 12;
    localparam int ADDR_W   = 10;
    localparam int DECIM_W  = 3;
    localparam int DCNT_W   = 7;

    localparam int DEF_N_SAMPLES    = 640;
    localparam int DEF_HOLDOFF      = 65536;
    localparam int DEF_AUTO_TIMEOUT = 1048576;

    // Terminal count of the decimation counter: 2^decim - 1.
    function automatic logic [DCNT_W-1:0] decim_mask(input logic [DECIM_W-1:0] d);
        logic [DCNT_W:0] one_hot;
        one_hot = (DCNT_W+1)'(1) << d;
        return DCNT_W'(one_hot - (DCNT_W+1)'(1));
    endfunction

endpackage

// File: rtl/trig_detect.sv
// Edge trigger: holds the previous valid sample and compares it with the current one against the level.
// Latency: trig is combinational on the strobe cycle; prev updates on each valid strobe.
// Backpressure: none; every sample_valid strobe is consumed.
module trig_detect
    import dso_pkg::*;
(
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_falling,
    output logic                trig
);

    logic [SAMPLE_W-1:0] prev;
    logic                rise_hit;
    logic                fall_hit;

    // Track the last valid sample in every FSM state so the first armed strobe already has history.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev <= '0;
        end else if (sample_valid) begin
            prev <= sample;
        end
    end

    // Threshold crossing in the selected direction, qualified by the strobe.
    always_comb begin
        rise_hit = (prev < trig_level) && (sample >= trig_level);
        fall_hit = (prev > trig_level) && (sample <= trig_level);
        trig     = sample_valid && (trig_falling ? fall_hit : rise_hit);
    end

endmodule

// File: rtl/trigger_capture.sv
// Triggered frame capture: arms, waits for an edge (or timeout), writes N_SAMPLES decimated samples, holds off.
// Latency: write strobe/address/data are registered on the same edge that samples sample_valid.
// Backpressure: none; the frame RAM is assumed to accept one write per cycle.
module trigger_capture
    import dso_pkg::*;
#(
    parameter int N_SAMPLES    = DEF_N_SAMPLES,
    parameter int HOLDOFF      = DEF_HOLDOFF,
    parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_falling,
    input  logic [DECIM_W-1:0]  decim,
    input  logic                single,
    input  logic                arm,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                frame_done,
    output logic                triggered,
    output logic                auto_trig
);

    localparam int AQ_W   = ADDR_W + 1;
    localparam int TMO_W  = $clog2(AUTO_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [AQ_W-1:0]   FRAME_END = AQ_W'(N_SAMPLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    state_t              state;
    logic                trig;
    logic                force_q;   // timeout expired: next strobe starts the frame
    logic [AQ_W-1:0]     addr_q;    // address of the next write; one wider to hold the end count
    logic [DCNT_W-1:0]   dec_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    trig_detect u_trig_detect (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .trig         (trig)
    );

    // Capture FSM with registered RAM write port and status flags.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            triggered  <= 1'b0;
            auto_trig  <= 1'b0;
            force_q    <= 1'b0;
            addr_q     <= '0;
            dec_cnt    <= '0;
            tmo_cnt    <= '0;
            hold_cnt   <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Continuous mode re-arms by itself; single-shot waits for a pulse.
                    if (arm || !single) begin
                        state   <= ST_ARMED;
                        tmo_cnt <= '0;
                        force_q <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (sample_valid && (trig || force_q)) begin
                        // The triggering sample itself is the first column of the frame.
                        state     <= ST_CAPTURE;
                        wr_en     <= 1'b1;
                        wr_addr   <= '0;
                        wr_data   <= sample;
                        addr_q    <= AQ_W'(1);
                        dec_cnt   <= '0;
                        triggered <= 1'b1;
                        auto_trig <= !trig;
                    end else if (tmo_cnt == TMO_LAST) begin
                        force_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (addr_q == FRAME_END) begin
                        // Cycle after the last write: close the frame.
                        state      <= ST_HOLDOFF;
                        frame_done <= 1'b1;
                        triggered  <= 1'b0;
                        wr_addr    <= '0;
                        addr_q     <= '0;
                        hold_cnt   <= '0;
                    end else if (sample_valid) begin
                        // >= so a mid-frame drop in decim takes effect on this strobe.
                        if (dec_cnt >= decim_mask(decim)) begin
                            dec_cnt <= '0;
                            wr_en   <= 1'b1;
                            wr_addr <= addr_q[ADDR_W-1:0];
                            wr_data <= sample;
                            addr_q  <= addr_q + AQ_W'(1);
                        end else begin
                            dec_cnt <= dec_cnt + DCNT_W'(1);
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= single ? ST_IDLE : ST_ARMED;
                        tmo_cnt <= '0;
                        force_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
module tb_trigger_capture;

    localparam int NS = 640;
    localparam int HO = 200;
    localparam int AT = 2000;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [11:0] sample;
    logic        sample_valid;
    logic [11:0] trig_level;
    logic        trig_falling;
    logic [2:0]  decim;
    logic        single;
    logic        arm;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_done;
    logic        triggered;
    logic        auto_trig;

    int n_vec = 0;
    int n_err = 0;

    // Write monitor state (owned by the monitor process only).
    logic [11:0] ram [0:1023];
    int          wr_cnt = 0;
    int          fd_cnt = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          fd_cyc = 0;
    int          a0_cyc = 0;
    logic [9:0]  last_addr = '0;

    int rel_cyc;
    int base_wr;
    int base_fd;

    trigger_capture #(
        .N_SAMPLES    (NS),
        .HOLDOFF      (HO),
        .AUTO_TIMEOUT (AT)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .decim        (decim),
        .single       (single),
        .arm          (arm),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .triggered    (triggered),
        .auto_trig    (auto_trig)
    );

    always #10 CLOCK = ~CLOCK;

    // Frame RAM model fed from the write port, sampled on the falling edge.
    always @(negedge CLOCK) begin
        cyc = cyc + 1;
        if (wr_en) begin
            ram[wr_addr] = wr_data;
            last_addr    = wr_addr;
            last_cyc     = cyc;
            if (wr_addr == 10'd0) a0_cyc = cyc;
            wr_cnt = wr_cnt + 1;
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
    end

    task automatic ramp(input int start, input int step, input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            int v;
            v = start + i * step;
            if (v > 4095) v = 4095;
            if (v < 0) v = 0;
            @(negedge CLOCK);
            sample       = 12'(v);
            sample_valid = 1'b1;
            @(negedge CLOCK);
            sample_valid = 1'b0;
            repeat (gap - 2) @(negedge CLOCK);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
        rel_cyc = cyc;
        base_wr = wr_cnt;
        base_fd = fd_cnt;
    endtask

    task automatic pulse_arm();
        @(negedge CLOCK);
        arm = 1'b1;
        @(negedge CLOCK);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLOCK);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        n_vec++; if (wr_addr !== 10'd0) begin n_err++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
        n_vec++; if (wr_data !== 12'd0) begin n_err++; $display("FAIL rst_wr_data: got %0d want 0", wr_data); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL rst_triggered: got %b want 0", triggered); end
        n_vec++; if (auto_trig !== 1'b0) begin n_err++; $display("FAIL rst_auto_trig: got %b want 0", auto_trig); end
    endtask

    task automatic test_rising();
        single = 1'b0; decim = 3'd0; trig_level = 12'd2048; trig_falling = 1'b0;
        do_reset();
        ramp(2040, 1, 648, 16);
        repeat (4) @(negedge CLOCK);
        n_vec++; if (wr_cnt - base_wr !== 640) begin n_err++; $display("FAIL rise_count: got %0d want 640", wr_cnt - base_wr); end
        n_vec++; if (ram[0] !== 12'd2048) begin n_err++; $display("FAIL rise_a0: got %0d want 2048", ram[0]); end
        n_vec++; if (ram[1] !== 12'd2049) begin n_err++; $display("FAIL rise_a1: got %0d want 2049", ram[1]); end
        n_vec++; if (ram[639] !== 12'd2687) begin n_err++; $display("FAIL rise_a639: got %0d want 2687", ram[639]); end
        n_vec++; if (last_addr !== 10'd639) begin n_err++; $display("FAIL rise_last_addr: got %0d want 639", last_addr); end
        n_vec++; if (fd_cnt - base_fd !== 1) begin n_err++; $display("FAIL rise_fd_count: got %0d want 1", fd_cnt - base_fd); end
        n_vec++; if (fd_cyc !== last_cyc + 1) begin n_err++; $display("FAIL rise_fd_timing: got %0d want %0d", fd_cyc, last_cyc + 1); end
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL rise_trig_clear: got %b want 0", triggered); end
        n_vec++; if (wr_addr !== 10'd0) begin n_err++; $display("FAIL rise_addr_ret: got %0d want 0", wr_addr); end
        n_vec++; if (auto_trig !== 1'b0) begin n_err++; $display("FAIL rise_auto: got %b want 0", auto_trig); end
    endtask

    task automatic test_decim();
        single = 1'b0; decim = 3'd2; trig_level = 12'd2048; trig_falling = 1'b0;
        do_reset();
        ramp(2040, 1, 2565, 4);
        repeat (4) @(negedge CLOCK);
        n_vec++; if (wr_cnt - base_wr !== 640) begin n_err++; $display("FAIL dec_count: got %0d want 640", wr_cnt - base_wr); end
        n_vec++; if (ram[0] !== 12'd2048) begin n_err++; $display("FAIL dec_a0: got %0d want 2048", ram[0]); end
        n_vec++; if (ram[1] !== 12'd2052) begin n_err++; $display("FAIL dec_a1: got %0d want 2052", ram[1]); end
        n_vec++; if (ram[2] !== 12'd2056) begin n_err++; $display("FAIL dec_a2: got %0d want 2056", ram[2]); end
        n_vec++; if (ram[511] !== 12'd4092) begin n_err++; $display("FAIL dec_a511: got %0d want 4092", ram[511]); end
        n_vec++; if (ram[512] !== 12'd4095) begin n_err++; $display("FAIL dec_a512: got %0d want 4095", ram[512]); end
        n_vec++; if (ram[639] !== 12'd4095) begin n_err++; $display("FAIL dec_a639: got %0d want 4095", ram[639]); end
        n_vec++; if (fd_cnt - base_fd !== 1) begin n_err++; $display("FAIL dec_fd_count: got %0d want 1", fd_cnt - base_fd); end
        decim = 3'd0;
    endtask

    task automatic test_auto();
        single = 1'b0; decim = 3'd0; trig_level = 12'd2048; trig_falling = 1'b0;
        do_reset();
        ramp(100, 0, 1160, 4);
        n_vec++; if (wr_cnt - base_wr !== 640) begin n_err++; $display("FAIL auto_count: got %0d want 640", wr_cnt - base_wr); end
        n_vec++; if (ram[0] !== 12'd100) begin n_err++; $display("FAIL auto_a0: got %0d want 100", ram[0]); end
        n_vec++; if (ram[639] !== 12'd100) begin n_err++; $display("FAIL auto_a639: got %0d want 100", ram[639]); end
        n_vec++; if ((a0_cyc - rel_cyc < AT) || (a0_cyc - rel_cyc > AT + 10))
            begin n_err++; $display("FAIL auto_start_time: got %0d cycles want %0d..%0d", a0_cyc - rel_cyc, AT, AT + 10); end
        n_vec++; if (fd_cnt - base_fd !== 1) begin n_err++; $display("FAIL auto_fd_count: got %0d want 1", fd_cnt - base_fd); end
        repeat (300) @(negedge CLOCK);
        n_vec++; if (auto_trig !== 1'b1) begin n_err++; $display("FAIL auto_flag: got %b want 1", auto_trig); end
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL auto_trig_idle: got %b want 0", triggered); end
        // A genuine crossing afterwards clears the auto flag.
        ramp(2040, 1, 11, 4);
        n_vec++; if (auto_trig !== 1'b0) begin n_err++; $display("FAIL auto_flag_clear: got %b want 0", auto_trig); end
        n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL auto_real_trig: got %b want 1", triggered); end
        n_vec++; if (ram[0] !== 12'd2048) begin n_err++; $display("FAIL auto_real_a0: got %0d want 2048", ram[0]); end
        n_vec++; if (wr_cnt - base_wr !== 643) begin n_err++; $display("FAIL auto_real_count: got %0d want 643", wr_cnt - base_wr); end
    endtask

    task automatic test_single();
        single = 1'b1; decim = 3'd0; trig_level = 12'd2048; trig_falling = 1'b0;
        do_reset();
        ramp(2040, 1, 21, 4);
        n_vec++; if (wr_cnt - base_wr !== 0) begin n_err++; $display("FAIL single_unarmed: got %0d want 0", wr_cnt - base_wr); end
        pulse_arm();
        ramp(2040, 1, 661, 4);
        repeat (HO + 20) @(negedge CLOCK);
        n_vec++; if (wr_cnt - base_wr !== 640) begin n_err++; $display("FAIL single_count: got %0d want 640", wr_cnt - base_wr); end
        n_vec++; if (ram[639] !== 12'd2687) begin n_err++; $display("FAIL single_a639: got %0d want 2687", ram[639]); end
        n_vec++; if (fd_cnt - base_fd !== 1) begin n_err++; $display("FAIL single_fd_count: got %0d want 1", fd_cnt - base_fd); end
        ramp(2040, 1, 21, 4);
        n_vec++; if (wr_cnt - base_wr !== 640) begin n_err++; $display("FAIL single_idle_again: got %0d want 640", wr_cnt - base_wr); end
        pulse_arm();
        ramp(2040, 1, 11, 4);
        n_vec++; if (wr_cnt - base_wr !== 643) begin n_err++; $display("FAIL single_rearm_count: got %0d want 643", wr_cnt - base_wr); end
        n_vec++; if (ram[2] !== 12'd2050) begin n_err++; $display("FAIL single_rearm_a2: got %0d want 2050", ram[2]); end
        single = 1'b0;
    endtask

    task automatic test_falling();
        single = 1'b0; decim = 3'd0; trig_level = 12'd1000; trig_falling = 1'b1;
        do_reset();
        ramp(1010, -1, 15, 4);
        n_vec++; if (wr_cnt - base_wr !== 5) begin n_err++; $display("FAIL fall_count: got %0d want 5", wr_cnt - base_wr); end
        n_vec++; if (ram[0] !== 12'd1000) begin n_err++; $display("FAIL fall_a0: got %0d want 1000", ram[0]); end
        n_vec++; if (ram[4] !== 12'd996) begin n_err++; $display("FAIL fall_a4: got %0d want 996", ram[4]); end
        n_vec++; if (last_addr !== 10'd4) begin n_err++; $display("FAIL fall_last_addr: got %0d want 4", last_addr); end
        n_vec++; if (auto_trig !== 1'b0) begin n_err++; $display("FAIL fall_auto: got %b want 0", auto_trig); end
        trig_falling = 1'b0; trig_level = 12'd2048;
    endtask

    task automatic test_reset_mid();
        single = 1'b0; decim = 3'd0; trig_level = 12'd2048; trig_falling = 1'b0;
        do_reset();
        ramp(2040, 1, 308, 4);
        repeat (2) @(negedge CLOCK);
        n_vec++; if (wr_addr !== 10'd299) begin n_err++; $display("FAIL mid_pre_addr: got %0d want 299", wr_addr); end
        n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL mid_pre_trig: got %b want 1", triggered); end
        #3 RESET_N = 1'b0;
        #1;
        n_vec++; if (wr_addr !== 10'd0) begin n_err++; $display("FAIL mid_rst_addr: got %0d want 0", wr_addr); end
        n_vec++; if (wr_data !== 12'd0) begin n_err++; $display("FAIL mid_rst_data: got %0d want 0", wr_data); end
        n_vec++; if (triggered !== 1'b0) begin n_err++; $display("FAIL mid_rst_trig: got %b want 0", triggered); end
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr_en: got %b want 0", wr_en); end
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
        rel_cyc = cyc;
        base_wr = wr_cnt;
        ramp(2030, 1, 31, 4);
        n_vec++; if (wr_cnt - base_wr !== 13) begin n_err++; $display("FAIL mid_post_count: got %0d want 13", wr_cnt - base_wr); end
        n_vec++; if (last_addr !== 10'd12) begin n_err++; $display("FAIL mid_post_last_addr: got %0d want 12", last_addr); end
        n_vec++; if (ram[12] !== 12'd2060) begin n_err++; $display("FAIL mid_post_a12: got %0d want 2060", ram[12]); end
        n_vec++; if (a0_cyc <= rel_cyc) begin n_err++; $display("FAIL mid_post_restart: got cycle %0d want after %0d", a0_cyc, rel_cyc); end
    endtask

    initial begin
        RESET_N      = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        trig_level   = 12'd2048;
        trig_falling = 1'b0;
        decim        = 3'd0;
        single       = 1'b0;
        arm          = 1'b0;
        test_reset();
        test_rising();
        test_decim();
        test_auto();
        test_single();
        test_falling();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
